// File: rtl/spi_regfile_pkg.sv
// Shared types and address-map helpers for the SPI register block.
//   state_e   : byte-level framing state (address byte vs data bytes)
//   bpc       : bytes needed to hold one channel word
//   ro_base   : first read-only (channel) address
//   last_addr : highest valid address
package spi_regfile_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  function automatic int bpc(input int ch_w);
    return (ch_w + 7) / 8;
  endfunction

  function automatic int ro_base(input int num_rw);
    return num_rw + 1;
  endfunction

  function automatic int last_addr(input int num_rw, input int num_ch, input int ch_w);
    return num_rw + num_ch * bpc(ch_w);
  endfunction

endpackage

// File: rtl/spi_regfile_edge_sync.sv
// Synchroniser for an asynchronous pin sampled as data, with single-cycle
// rise/fall pulses derived from the synchronised level.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   d_i     : asynchronous input pin
//   level_o : synchronised level
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
//   fall_o  : one-cycle pulse on a synchronised 1->0 transition
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  if (STAGES < 2) begin : g_stage_check
    $error("edge_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_regfile.sv
// SPI slave register block, oversampled on clk.
// Byte-addressed map with auto-incrementing pointer:
//   0                : reserved, reads 0
//   1..NUM_RW        : writable configuration bytes (regs_o)
//   RO_BASE..LAST    : read-only channel bytes from a snapshot taken at the
//                      address byte
//   above LAST       : invalid, reads 0 and sets addr_err_o
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   sclk_i       : serial clock from master (async)
//   iclk_i       : frame-reset pulse line (async)
//   serial_in    : serial data in, LSB first
//   serial_out   : serial data out, LSB first
//   ch_data_i    : NUM_CH channel words of CH_W bits
//   regs_o       : writable register contents, addr a at [(a-1)*8 +: 8]
//   wr_stb_o     : one-cycle write strobe per register
//   addr_err_o   : sticky invalid-address flag, cleared by frame reset
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CH_W        = 50,
  parameter int NUM_RW      = 3,
  parameter int RST_PULSES  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk_i,
  input  logic                     iclk_i,
  input  logic                     serial_in,
  output logic                     serial_out,
  input  logic [NUM_CH*CH_W-1:0]   ch_data_i,
  output logic [NUM_RW*8-1:0]      regs_o,
  output logic [NUM_RW-1:0]        wr_stb_o,
  output logic                     addr_err_o
);

  localparam int BPC     = bpc(CH_W);
  localparam int RO_BASE = ro_base(NUM_RW);
  localparam int LAST    = last_addr(NUM_RW, NUM_CH, CH_W);
  localparam int CNT_W   = $clog2(RST_PULSES + 1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST);

  if (LAST > 255) begin : g_addr_check
    $error("spi_regfile: address map does not fit in 8 bits");
  end

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic iclk_lvl, iclk_rise, iclk_fall;

  edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (sclk_i),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_iclk_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (iclk_i),
    .level_o (iclk_lvl),
    .rise_o  (iclk_rise),
    .fall_o  (iclk_fall)
  );

  logic unused_iclk;
  assign unused_iclk = &{1'b0, iclk_lvl, iclk_fall};

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             rx_q, rx_d;
  logic [7:0]             tx_q, tx_d;
  logic                   skip_q, skip_d;
  logic [NUM_RW*8-1:0]    regs_q, regs_d;
  logic [NUM_CH*CH_W-1:0] snap_q, snap_d;
  logic                   err_q, err_d;
  logic [NUM_RW-1:0]      stb_q, stb_d;
  logic [CNT_W-1:0]       icnt_q, icnt_d;

  // Byte visible at address a, given the register contents and a channel
  // source (live inputs at the address byte, snapshot afterwards).
  function automatic logic [7:0] byte_at(input logic [NUM_RW*8-1:0]    regs,
                                         input logic [NUM_CH*CH_W-1:0] chs,
                                         input logic [ADDR_W-1:0]      a);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (int'(a) == i + 1) r = regs[i*8 +: 8];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      for (int b = 0; b < BPC; b++) begin
        if (int'(a) == RO_BASE + k*BPC + b) begin
          for (int j = 0; j < 8; j++) begin
            if (b*8 + j < CH_W) r[j] = chs[k*CH_W + b*8 + j];
          end
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ADDR;
      ptr_q     <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      skip_q    <= 1'b0;
      regs_q    <= '0;
      snap_q    <= '0;
      err_q     <= 1'b0;
      stb_q     <= '0;
      icnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      skip_q    <= skip_d;
      regs_q    <= regs_d;
      snap_q    <= snap_d;
      err_q     <= err_d;
      stb_q     <= stb_d;
      icnt_q    <= icnt_d;
    end
  end

  always_comb begin
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] ptr_inc;

    state_d   = state_q;
    ptr_d     = ptr_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    skip_d    = skip_q;
    regs_d    = regs_q;
    snap_d    = snap_q;
    err_d     = err_q;
    stb_d     = '0;
    icnt_d    = icnt_q;
    rx_byte   = {serial_in, rx_q};
    ptr_inc   = ptr_q + ADDR_W'(1);

    if (sclk_rise) begin
      // serial_in is held stable across the synchroniser window, so the
      // raw pin is sampled directly at the detected rise.
      icnt_d    = '0;
      rx_d      = rx_byte[7:1];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        // bit 0 of the freshly loaded byte is already on serial_out, so the
        // fall that follows the boundary must not shift.
        skip_d = 1'b1;
        if (state_q == ST_ADDR) begin
          ptr_d   = rx_byte;
          snap_d  = ch_data_i;
          tx_d    = byte_at(regs_q, ch_data_i, rx_byte);
          state_d = ST_DATA;
        end else begin
          for (int r = 0; r < NUM_RW; r++) begin
            if (ptr_q == ADDR_W'(r + 1)) begin
              regs_d[r*8 +: 8] = rx_byte;
              stb_d[r]         = 1'b1;
            end
          end
          if (ptr_q > LAST_A) err_d = 1'b1;
          ptr_d = ptr_inc;
          tx_d  = byte_at(regs_q, snap_q, ptr_inc);
        end
      end
    end else begin
      if (sclk_fall) begin
        if (skip_q) skip_d = 1'b0;
        else        tx_d   = {1'b0, tx_q[7:1]};
      end
      if (iclk_rise && !sclk_lvl) begin
        if (icnt_q == CNT_W'(RST_PULSES - 1)) begin
          ptr_d     = '0;
          bit_cnt_d = '0;
          state_d   = ST_ADDR;
          err_d     = 1'b0;
          icnt_d    = '0;
        end else begin
          icnt_d = icnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign serial_out = tx_q[0];
  assign regs_o     = regs_q;
  assign wr_stb_o   = stb_q;
  assign addr_err_o = err_q;

endmodule

// File: tb/tb_spi_regfile.sv
module tb_spi_regfile;

  localparam int NUM_CH     = 8;
  localparam int CH_W       = 50;
  localparam int NUM_RW     = 3;
  localparam int RST_PULSES = 8;
  localparam int BPC        = (CH_W + 7) / 8;
  localparam int RO_BASE    = NUM_RW + 1;
  localparam int LAST       = NUM_RW + NUM_CH * BPC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic iclk = 1'b0;
  logic serial_in = 1'b0;
  logic serial_out;
  logic [NUM_CH*CH_W-1:0] ch_data = '0;
  logic [NUM_RW*8-1:0]    regs_o;
  logic [NUM_RW-1:0]      wr_stb;
  logic                   addr_err;

  int checks = 0;
  int errors = 0;

  spi_regfile #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .NUM_RW(NUM_RW),
    .RST_PULSES(RST_PULSES), .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk_i     (sclk),
    .iclk_i     (iclk),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .ch_data_i  (ch_data),
    .regs_o     (regs_o),
    .wr_stb_o   (wr_stb),
    .addr_err_o (addr_err)
  );

  always #5 clk = ~clk;

  int stb_cnt [NUM_RW];
  always @(posedge clk) begin
    for (int i = 0; i < NUM_RW; i++)
      if (!rst && wr_stb[i]) stb_cnt[i] = stb_cnt[i] + 1;
  end

  // ---------------- reference model ----------------
  logic [7:0]             m_regs [1:NUM_RW];
  logic [NUM_CH*CH_W-1:0] m_snap;
  logic [7:0]             m_ptr;
  bit                     m_in_data;
  bit                     m_err;
  int                     m_icnt;
  int                     m_stb [NUM_RW];

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int ai, idx, k, b;
    logic [63:0] w;
    ai = int'(a);
    if (ai == 0) return 8'h00;
    if (ai <= NUM_RW) return m_regs[ai];
    if (ai <= LAST) begin
      idx = ai - RO_BASE;
      k = idx / BPC;
      b = idx % BPC;
      w = '0;
      w[CH_W-1:0] = m_snap[k*CH_W +: CH_W];
      return w[8*b +: 8];
    end
    return 8'h00;
  endfunction

  function automatic logic [NUM_RW*8-1:0] m_regs_flat();
    logic [NUM_RW*8-1:0] f;
    for (int a = 1; a <= NUM_RW; a++) f[(a-1)*8 +: 8] = m_regs[a];
    return f;
  endfunction

  task automatic m_reset();
    for (int a = 1; a <= NUM_RW; a++) m_regs[a] = 8'h00;
    m_snap = '0; m_ptr = 8'h00; m_in_data = 0; m_err = 0; m_icnt = 0;
  endtask

  // ---------------- stimulus ----------------
  task automatic xfer(input logic [7:0] b, output logic [7:0] rd);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (5) @(negedge clk);
      rd[i] = serial_out;
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
  endtask

  // Sends one byte to DUT and model; exp/has_exp give the byte the master
  // should read back during it.
  task automatic send(input logic [7:0] b, output logic [7:0] rd,
                      output logic [7:0] exp, output bit has_exp);
    m_icnt = 0;
    if (!m_in_data) begin
      m_ptr = b; m_snap = ch_data; m_in_data = 1;
      has_exp = 0; exp = 8'h00;
    end else begin
      exp = m_read(m_ptr);
      has_exp = 1;
      if (int'(m_ptr) >= 1 && int'(m_ptr) <= NUM_RW) begin
        m_regs[int'(m_ptr)] = b;
        m_stb[int'(m_ptr) - 1]++;
      end
      if (int'(m_ptr) > LAST) m_err = 1;
      m_ptr = m_ptr + 8'd1;
    end
    xfer(b, rd);
  endtask

  task automatic send_bits(input int n);
    m_icnt = 0;
    for (int i = 0; i < n; i++) begin
      serial_in = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic iclk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      iclk = 1'b1;
      repeat (5) @(negedge clk);
      iclk = 1'b0;
      repeat (5) @(negedge clk);
      m_icnt++;
      if (m_icnt == RST_PULSES) begin
        m_icnt = 0; m_ptr = 8'h00; m_in_data = 0; m_err = 0;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic randomize_ch();
    logic [63:0] t;
    for (int k = 0; k < NUM_CH; k++) begin
      t = {$urandom, $urandom};
      ch_data[k*CH_W +: CH_W] = t[CH_W-1:0];
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (regs_o !== '0) begin errors++; $display("FAIL reset_regs: got %h expected 0", regs_o); end
    checks++; if (wr_stb !== '0) begin errors++; $display("FAIL reset_stb: got %b expected 0", wr_stb); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", addr_err); end
    checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b expected 0", serial_out); end
    rst = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_cycle();
    logic [7:0] rd, exp; bit he;
    logic [7:0] data [4] = '{8'h01, 8'h10, 8'h20, 8'h30};
    for (int i = 0; i < 4; i++) send(data[i], rd, exp, he);
    iclk_pulses(8);
    checks++; if (regs_o !== 24'h302010) begin errors++; $display("FAIL write_regs: got %h expected 302010", regs_o); end
    for (int i = 0; i < NUM_RW; i++) begin
      checks++;
      if (stb_cnt[i] !== 1) begin errors++; $display("FAIL write_stb%0d: got %0d pulses expected 1", i, stb_cnt[i]); end
    end
  endtask

  task automatic test_readback();
    logic [7:0] rd, exp; bit he;
    logic [7:0] data [4] = '{8'h01, 8'h10, 8'h20, 8'h30};
    logic [7:0] want [4] = '{8'h00, 8'h10, 8'h20, 8'h30};
    iclk_pulses(8);
    for (int i = 0; i < 4; i++) begin
      send(data[i], rd, exp, he);
      if (he) begin
        checks++;
        if (rd !== want[i] || rd !== exp) begin errors++; $display("FAIL readback%0d: got %h expected %h", i, rd, want[i]); end
      end
    end
    checks++; if (stb_cnt[1] !== m_stb[1]) begin errors++; $display("FAIL readback_stb: got %0d expected %0d", stb_cnt[1], m_stb[1]); end
  endtask

  task automatic test_channels();
    logic [7:0] rd, exp; bit he;
    logic [7:0] ch0_want [7] = '{8'hD3, 8'hD2, 8'hD2, 8'hD2, 8'hD2, 8'hD2, 8'h02};
    int bad;
    iclk_pulses(8);
    randomize_ch();
    ch_data[0*CH_W +: CH_W] = 50'h2D2D2D2D2D2D3;
    ch_data[3*CH_W +: CH_W] = 50'h3FFFFFFFFFFFF;
    send(8'h04, rd, exp, he);
    bad = 0;
    for (int j = 0; j < NUM_CH*BPC; j++) begin
      send($urandom_range(0, 255), rd, exp, he);
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL chan_byte%0d: got %h expected %h", j, rd, exp); end
      if (j < 7) begin
        checks++;
        if (rd !== ch0_want[j]) begin errors++; $display("FAIL ch0_byte%0d: got %h expected %h", j, rd, ch0_want[j]); end
      end
      if (j == 3*BPC + 6) begin
        checks++;
        if (rd !== 8'h03) begin errors++; $display("FAIL ch3_top: got %h expected 03", rd); end
      end
    end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL chan_err: got %b expected 0", addr_err); end
  endtask

  task automatic test_snapshot();
    logic [7:0] rd, exp; bit he;
    iclk_pulses(8);
    randomize_ch();
    send(8'h04, rd, exp, he);
    ch_data = ~ch_data;
    for (int j = 0; j < BPC; j++) begin
      send(8'h00, rd, exp, he);
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL snapshot%0d: got %h expected %h", j, rd, exp); end
    end
  endtask

  task automatic test_invalid();
    logic [7:0] rd, exp; bit he;
    int s [NUM_RW];
    logic [7:0] wb;
    iclk_pulses(8);
    for (int i = 0; i < NUM_RW; i++) s[i] = stb_cnt[i];
    send(8'h60, rd, exp, he);
    send(8'h5A, rd, exp, he);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL inv_read: got %h expected 00", rd); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL inv_err: got %b expected 1", addr_err); end
    for (int i = 0; i < NUM_RW; i++) begin
      checks++;
      if (stb_cnt[i] !== s[i]) begin errors++; $display("FAIL inv_stb%0d: got %0d expected %0d", i, stb_cnt[i], s[i]); end
    end
    iclk_pulses(8);
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL inv_clear: got %b expected 0", addr_err); end
    // pointer wrap 0xFE -> 0xFF -> 0x00 -> 0x01
    send(8'hFE, rd, exp, he);
    for (int j = 0; j < 4; j++) begin
      wb = 8'(8'hC0 + j);
      send(wb, rd, exp, he);
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL wrap_read%0d: got %h expected %h", j, rd, exp); end
    end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL wrap_err: got %b expected 1", addr_err); end
    checks++; if (regs_o !== m_regs_flat()) begin errors++; $display("FAIL wrap_regs: got %h expected %h", regs_o, m_regs_flat()); end
  endtask

  task automatic test_interrupted();
    logic [7:0] rd, exp; bit he;
    iclk_pulses(8);
    send_bits(3);
    iclk_pulses(8);
    send(8'h02, rd, exp, he);
    send(8'hAA, rd, exp, he);
    checks++; if (regs_o[15:8] !== 8'hAA) begin errors++; $display("FAIL intr_reg2: got %h expected aa", regs_o[15:8]); end
    checks++; if (regs_o !== m_regs_flat()) begin errors++; $display("FAIL intr_regs: got %h expected %h", regs_o, m_regs_flat()); end
  endtask

  task automatic test_short_iclk();
    logic [7:0] rd, exp; bit he;
    iclk_pulses(8);
    send(8'h01, rd, exp, he);
    send(8'h11, rd, exp, he);
    iclk_pulses(7);
    send(8'h22, rd, exp, he);
    checks++; if (rd !== exp) begin errors++; $display("FAIL short_read: got %h expected %h", rd, exp); end
    iclk_pulses(1);
    send(8'h33, rd, exp, he);
    checks++; if (regs_o !== 24'h332211) begin errors++; $display("FAIL short_regs: got %h expected 332211", regs_o); end
  endtask

  task automatic test_rst_midbyte();
    logic [7:0] rd, exp; bit he;
    iclk_pulses(8);
    send(8'h01, rd, exp, he);
    send_bits(4);
    for (int i = 0; i < NUM_RW; i++) stb_cnt[i] = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < NUM_RW; i++) m_stb[i] = 0;
    send_bits(4);
    @(negedge clk);
    checks++; if (regs_o !== '0) begin errors++; $display("FAIL rstmid_regs: got %h expected 0", regs_o); end
    checks++; if (stb_cnt[0] !== 0) begin errors++; $display("FAIL rstmid_stb: got %0d expected 0", stb_cnt[0]); end
    checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL rstmid_sout: got %b expected 0", serial_out); end
    // the 4 post-reset bits must be forgotten by the next frame reset
    iclk_pulses(8);
  endtask

  task automatic test_random();
    logic [7:0] rd, exp, addr; bit he;
    int n;
    for (int f = 0; f < 10; f++) begin
      iclk_pulses(8);
      randomize_ch();
      addr = 8'($urandom_range(0, 70));
      send(addr, rd, exp, he);
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        send(8'($urandom), rd, exp, he);
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL rand_f%0d_b%0d: got %h expected %h", f, j, rd, exp); end
      end
      checks++; if (regs_o !== m_regs_flat()) begin errors++; $display("FAIL rand_regs%0d: got %h expected %h", f, regs_o, m_regs_flat()); end
      checks++; if (addr_err !== m_err) begin errors++; $display("FAIL rand_err%0d: got %b expected %b", f, addr_err, m_err); end
      for (int i = 0; i < NUM_RW; i++) begin
        checks++;
        if (stb_cnt[i] !== m_stb[i]) begin errors++; $display("FAIL rand_stb%0d_%0d: got %0d expected %0d", f, i, stb_cnt[i], m_stb[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_RW; i++) begin stb_cnt[i] = 0; m_stb[i] = 0; end
    m_reset();
    test_reset();
    test_write_cycle();
    test_readback();
    test_channels();
    test_snapshot();
    test_invalid();
    test_interrupted();
    test_short_iclk();
    test_rst_midbyte();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
